core_seq: RTL and testbench

- Parametrised multi-cycle control sequencer for the single-issue RISC-V core; successor to the current fetch/load/store/exec controller.
- Sequences IFU and LSU request/response handshakes and generates pc/reg/lsu write enables, a retire pulse and an ebreak flag.
- Adds bus-error and timeout trapping, an optional halt on ebreak, and a retired-instruction counter.
- Sits between the IFU/LSU bus masters and the datapath.

---
 rtl/core_seq_pkg.sv | 33 +++
 rtl/core_seq_inflight.sv | 48 ++++
 rtl/core_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_core_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and encodings for the core_seq control sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    StStart = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StStore = 3'd3,
    StExec  = 3'd4,
    StHalt  = 3'd5,
    StTrap  = 3'd6
  } state_e;

  // Decoded instruction classes driven by the datapath decoder.
  localparam logic [3:0] INST_ALU       = 4'd0;
  localparam logic [3:0] INST_LOAD_BYTE = 4'd1;
  localparam logic [3:0] INST_LOAD_HALF = 4'd2;
  localparam logic [3:0] INST_LOAD_WORD = 4'd3;
  localparam logic [3:0] INST_STORE     = 4'd4;
  localparam logic [3:0] INST_BRANCH    = 4'd5;
  localparam logic [3:0] INST_JUMP      = 4'd6;
  localparam logic [3:0] INST_EBREAK    = 4'd7;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_IFU     = 2'd1;
  localparam logic [1:0] TRAP_LSU     = 2'd2;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

  function automatic logic is_load(logic [3:0] t);
    return (t == INST_LOAD_BYTE) || (t == INST_LOAD_HALF) || (t == INST_LOAD_WORD);
  endfunction

endpackage

// File: rtl/core_seq_inflight.sv
// Per-channel request tracker: inflight flag, wait counter, response accept and watchdog timeout.
module core_seq_inflight #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned WAIT_W         = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid_i,
  input  logic resp_valid_i,
  input  logic wait_clear_i,
  input  logic in_wait_i,
  output logic accept_o,
  output logic timeout_o
);

  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [WAIT_W-1:0] WaitLast = TimeoutEn ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic              inflight_q, inflight_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stalled;

  // Responses without an outstanding request (e.g. stale after reset) are dropped.
  assign accept_o  = resp_valid_i & inflight_q;
  assign stalled   = in_wait_i & ~accept_o;
  assign timeout_o = TimeoutEn & stalled & (wait_q == WaitLast);

  always_comb begin
    inflight_d = req_valid_i | (inflight_q & ~accept_o);
    wait_d     = wait_q;
    if (wait_clear_i) begin
      wait_d = '0;
    end else if (stalled) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/load/store/exec sequencer with trapping, halt and retire counting.
// Define CORE_SEQ_PERF_EN to build the IFU/LSU stall-cycle counters.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned WAIT_W         = 16,
  parameter int unsigned RETIRE_W       = 32,
  parameter int unsigned HALT_ON_EBREAK = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_respValid,
  input  logic                ifu_respErr,
  input  logic                lsu_respValid,
  input  logic                lsu_respErr,
  input  logic [3:0]          inst_type,
  output logic                ifu_reqValid,
  output logic                lsu_reqValid,
  output logic                lsu_wen,
  output logic                pc_wen,
  output logic                reg_wen,
  output logic                finished,
  output logic                ebreak,
  output logic                halted,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retire_count,
  output logic [31:0]         ifu_stall_cycles,
  output logic [31:0]         lsu_stall_cycles
);

  state_e              state_q, state_d;
  logic [1:0]          cause_d;
  logic                retire;
  logic                ifu_accept, ifu_timeout, lsu_accept, lsu_timeout;
  logic                ifu_clear, lsu_clear, lsu_in_wait, lsu_next_wait;
  logic                finished_q, finished_d, ebreak_q, ebreak_d;
  logic                halted_q, halted_d, trap_q, trap_d;
  logic [1:0]          trap_cause_q, trap_cause_d;
  logic [RETIRE_W-1:0] retire_count_q, retire_count_d;

  assign lsu_in_wait   = (state_q == StLoad) || (state_q == StStore);
  assign lsu_next_wait = (state_d == StLoad) || (state_d == StStore);
  assign ifu_clear     = (state_d == StFetch) && (state_q != StFetch);
  assign lsu_clear     = lsu_next_wait && !lsu_in_wait;

  core_seq_inflight #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WAIT_W        (WAIT_W)
  ) u_ifu_inflight (
    .clock       (clock),
    .reset       (reset),
    .req_valid_i (ifu_reqValid),
    .resp_valid_i(ifu_respValid),
    .wait_clear_i(ifu_clear),
    .in_wait_i   (state_q == StFetch),
    .accept_o    (ifu_accept),
    .timeout_o   (ifu_timeout)
  );

  core_seq_inflight #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WAIT_W        (WAIT_W)
  ) u_lsu_inflight (
    .clock       (clock),
    .reset       (reset),
    .req_valid_i (lsu_reqValid),
    .resp_valid_i(lsu_respValid),
    .wait_clear_i(lsu_clear),
    .in_wait_i   (lsu_in_wait),
    .accept_o    (lsu_accept),
    .timeout_o   (lsu_timeout)
  );

  // Error beats a good response, which beats the watchdog.
  always_comb begin
    state_d      = state_q;
    cause_d      = TRAP_NONE;
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    lsu_wen      = 1'b0;
    pc_wen       = 1'b0;
    reg_wen      = 1'b0;
    retire       = 1'b0;
    case (state_q)
      StStart: begin
        if (!reset) begin
          ifu_reqValid = 1'b1;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        if (ifu_accept && ifu_respErr) begin
          state_d = StTrap;
          cause_d = TRAP_IFU;
        end else if (ifu_accept) begin
          pc_wen = 1'b1;
          if (is_load(inst_type)) begin
            lsu_reqValid = 1'b1;
            state_d      = StLoad;
          end else if (inst_type == INST_STORE) begin
            lsu_reqValid = 1'b1;
            lsu_wen      = 1'b1;
            state_d      = StStore;
          end else begin
            reg_wen = 1'b1;
            state_d = StExec;
          end
        end else if (ifu_timeout) begin
          state_d = StTrap;
          cause_d = TRAP_TIMEOUT;
        end else begin
          ifu_reqValid = 1'b1;
        end
      end
      StLoad: begin
        if (lsu_accept && lsu_respErr) begin
          state_d = StTrap;
          cause_d = TRAP_LSU;
        end else if (lsu_accept) begin
          reg_wen = 1'b1;
          state_d = StExec;
        end else if (lsu_timeout) begin
          state_d = StTrap;
          cause_d = TRAP_TIMEOUT;
        end else begin
          lsu_reqValid = 1'b1;
        end
      end
      StStore: begin
        if (lsu_accept && lsu_respErr) begin
          state_d = StTrap;
          cause_d = TRAP_LSU;
        end else if (lsu_accept) begin
          retire       = 1'b1;
          ifu_reqValid = 1'b1;
          state_d      = StFetch;
        end else if (lsu_timeout) begin
          state_d = StTrap;
          cause_d = TRAP_TIMEOUT;
        end else begin
          lsu_reqValid = 1'b1;
          lsu_wen      = 1'b1;
        end
      end
      StExec: begin
        retire = 1'b1;
        if ((inst_type == INST_EBREAK) && (HALT_ON_EBREAK != 0)) begin
          state_d = StHalt;
        end else begin
          ifu_reqValid = 1'b1;
          state_d      = StFetch;
        end
      end
      StHalt, StTrap: ;
      default: begin
        ifu_reqValid = 1'b1;
        state_d      = StFetch;
      end
    endcase
  end

  always_comb begin
    finished_d     = retire;
    retire_count_d = retire_count_q + RETIRE_W'(retire);
    ebreak_d       = ebreak_q | ((state_d == StExec) && (inst_type == INST_EBREAK));
    halted_d       = halted_q | (state_d == StHalt);
    trap_d         = trap_q | (state_d == StTrap);
    trap_cause_d   = trap_cause_q;
    if ((state_d == StTrap) && (state_q != StTrap)) begin
      trap_cause_d = cause_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StStart;
      finished_q     <= 1'b0;
      ebreak_q       <= 1'b0;
      halted_q       <= 1'b0;
      trap_q         <= 1'b0;
      trap_cause_q   <= TRAP_NONE;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      finished_q     <= finished_d;
      ebreak_q       <= ebreak_d;
      halted_q       <= halted_d;
      trap_q         <= trap_d;
      trap_cause_q   <= trap_cause_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign finished     = finished_q;
  assign ebreak       = ebreak_q;
  assign halted       = halted_q;
  assign trap         = trap_q;
  assign trap_cause   = trap_cause_q;
  assign retire_count = retire_count_q;

`ifdef CORE_SEQ_PERF_EN
  logic        ifu_stalled, lsu_stalled;
  logic [31:0] ifu_stall_q, ifu_stall_d, lsu_stall_q, lsu_stall_d;

  assign ifu_stalled = (state_q == StFetch) && !ifu_accept;
  assign lsu_stalled = lsu_in_wait && !lsu_accept;

  always_comb begin
    ifu_stall_d = ifu_stall_q;
    lsu_stall_d = lsu_stall_q;
    if (ifu_stalled && (ifu_stall_q != '1)) ifu_stall_d = ifu_stall_q + 32'd1;
    if (lsu_stalled && (lsu_stall_q != '1)) lsu_stall_d = lsu_stall_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifu_stall_q <= '0;
      lsu_stall_q <= '0;
    end else begin
      ifu_stall_q <= ifu_stall_d;
      lsu_stall_q <= lsu_stall_d;
    end
  end

  assign ifu_stall_cycles = ifu_stall_q;
  assign lsu_stall_cycles = lsu_stall_q;
`else
  assign ifu_stall_cycles = '0;
  assign lsu_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq (TIMEOUT_CYCLES=8, HALT_ON_EBREAK=1).
module tb_core_seq;
  import core_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_respValid = 1'b0, ifu_respErr = 1'b0;
  logic        lsu_respValid = 1'b0, lsu_respErr = 1'b0;
  logic [3:0]  inst_type = INST_ALU;
  logic        ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen;
  logic        finished, ebreak, halted, trap;
  logic [1:0]  trap_cause;
  logic [31:0] retire_count, ifu_stall_cycles, lsu_stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  core_seq #(
    .TIMEOUT_CYCLES(8),
    .WAIT_W        (16),
    .RETIRE_W      (32),
    .HALT_ON_EBREAK(1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ifu_respValid   (ifu_respValid),
    .ifu_respErr     (ifu_respErr),
    .lsu_respValid   (lsu_respValid),
    .lsu_respErr     (lsu_respErr),
    .inst_type       (inst_type),
    .ifu_reqValid    (ifu_reqValid),
    .lsu_reqValid    (lsu_reqValid),
    .lsu_wen         (lsu_wen),
    .pc_wen          (pc_wen),
    .reg_wen         (reg_wen),
    .finished        (finished),
    .ebreak          (ebreak),
    .halted          (halted),
    .trap            (trap),
    .trap_cause      (trap_cause),
    .retire_count    (retire_count),
    .ifu_stall_cycles(ifu_stall_cycles),
    .lsu_stall_cycles(lsu_stall_cycles)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in START, 1ns after the edge on which reset was released.
  task automatic do_reset();
    reset = 1'b1;
    ifu_respValid = 1'b0; ifu_respErr = 1'b0;
    lsu_respValid = 1'b0; lsu_respErr = 1'b0;
    inst_type = INST_ALU;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000",
               {ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen});
    end
    checks++;
    if ({finished, ebreak, halted, trap, trap_cause} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {finished, ebreak, halted, trap, trap_cause});
    end
    checks++;
    if (retire_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_retire: got %0d want 0", retire_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ifu_reqValid !== 1'b1) begin
      errors++;
      $display("FAIL start_req: got %b want 1", ifu_reqValid);
    end
  endtask

  task automatic test_add();
    do_reset();
    tick();  // FETCH wait 1
    checks++;
    if ({ifu_reqValid, pc_wen} !== 2'b10) begin
      errors++;
      $display("FAIL add_wait: got %b want 10", {ifu_reqValid, pc_wen});
    end
    tick();  // FETCH wait 2
    tick();  // FETCH, response this cycle
    ifu_respValid = 1'b1;
    inst_type = INST_ALU;
    #1;
    checks++;
    if ({pc_wen, reg_wen, ifu_reqValid, lsu_reqValid} !== 4'b1100) begin
      errors++;
      $display("FAIL add_resp: got %b want 1100", {pc_wen, reg_wen, ifu_reqValid, lsu_reqValid});
    end
    tick();  // EXEC
    ifu_respValid = 1'b0;
    #1;
    checks++;
    if ({pc_wen, reg_wen, ifu_reqValid, finished} !== 4'b0010) begin
      errors++;
      $display("FAIL add_exec: got %b want 0010", {pc_wen, reg_wen, ifu_reqValid, finished});
    end
    tick();  // FETCH after retire
    checks++;
    if ({finished, retire_count} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL add_retire: got fin=%b cnt=%0d want fin=1 cnt=1", finished, retire_count);
    end
    tick();
    checks++;
    if (finished !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse: got %b want 0", finished);
    end
  endtask

  task automatic test_load();
    int   held;
    logic wen_seen;
    held = 0;
    wen_seen = 1'b0;
    do_reset();
    tick();  // FETCH
    inst_type = INST_LOAD_WORD;
    ifu_respValid = 1'b1;
    #1;
    checks++;
    if ({pc_wen, reg_wen, lsu_reqValid, lsu_wen, ifu_reqValid} !== 5'b10100) begin
      errors++;
      $display("FAIL load_issue: got %b want 10100",
               {pc_wen, reg_wen, lsu_reqValid, lsu_wen, ifu_reqValid});
    end
    held += int'(lsu_reqValid);
    tick();  // LOAD wait 1
    ifu_respValid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      held += int'(lsu_reqValid);
      if (reg_wen) wen_seen = 1'b1;
      tick();
    end
    lsu_respValid = 1'b1;
    #1;
    checks++;
    if ({reg_wen, lsu_reqValid, pc_wen} !== 3'b100) begin
      errors++;
      $display("FAIL load_resp: got %b want 100", {reg_wen, lsu_reqValid, pc_wen});
    end
    checks++;
    if (held != 5 || wen_seen !== 1'b0) begin
      errors++;
      $display("FAIL load_hold: got held=%0d early_wen=%b want held=5 early_wen=0", held, wen_seen);
    end
    tick();  // EXEC
    lsu_respValid = 1'b0;
    #1;
    checks++;
    if ({reg_wen, ifu_reqValid, lsu_reqValid} !== 3'b010) begin
      errors++;
      $display("FAIL load_exec: got %b want 010", {reg_wen, ifu_reqValid, lsu_reqValid});
    end
    tick();
    tick();
    checks++;
    if (retire_count !== 32'd1) begin
      errors++;
      $display("FAIL load_retire: got %0d want 1", retire_count);
    end
  endtask

  task automatic test_store_err();
    logic bad;
    bad = 1'b0;
    do_reset();
    tick();  // FETCH
    inst_type = INST_STORE;
    ifu_respValid = 1'b1;
    #1;
    checks++;
    if ({pc_wen, lsu_reqValid, lsu_wen, reg_wen, ifu_reqValid} !== 5'b11100) begin
      errors++;
      $display("FAIL store_issue: got %b want 11100",
               {pc_wen, lsu_reqValid, lsu_wen, reg_wen, ifu_reqValid});
    end
    tick();  // STORE wait
    ifu_respValid = 1'b0;
    #1;
    checks++;
    if ({lsu_reqValid, lsu_wen, ifu_reqValid} !== 3'b110) begin
      errors++;
      $display("FAIL store_wait: got %b want 110", {lsu_reqValid, lsu_wen, ifu_reqValid});
    end
    tick();  // STORE, error response plus a spurious fetch response
    ifu_respValid = 1'b1;
    lsu_respValid = 1'b1;
    lsu_respErr = 1'b1;
    #1;
    checks++;
    if ({ifu_reqValid, lsu_reqValid, pc_wen, reg_wen} !== 4'b0000) begin
      errors++;
      $display("FAIL store_err_cycle: got %b want 0000",
               {ifu_reqValid, lsu_reqValid, pc_wen, reg_wen});
    end
    tick();  // TRAP
    ifu_respValid = 1'b0;
    lsu_respValid = 1'b0;
    lsu_respErr = 1'b0;
    #1;
    checks++;
    if ({trap, trap_cause} !== 3'b110) begin
      errors++;
      $display("FAIL store_trap: got trap=%b cause=%0d want trap=1 cause=2", trap, trap_cause);
    end
    for (int i = 0; i < 5; i++) begin
      if ({ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen, finished} !== 6'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0 || retire_count !== 32'd0) begin
      errors++;
      $display("FAIL store_quiet: got activity=%b retire=%0d want activity=0 retire=0",
               bad, retire_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    do_reset();
    tick();  // FETCH wait 1
    while (trap !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d want 8", n);
    end
    checks++;
    if ({trap_cause, ifu_reqValid} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_cause: got cause=%0d req=%b want cause=3 req=0",
               trap_cause, ifu_reqValid);
    end
`ifndef CORE_SEQ_PERF_EN
    checks++;
    if ({ifu_stall_cycles, lsu_stall_cycles} !== 64'd0) begin
      errors++;
      $display("FAIL perf_tied: got ifu=%0d lsu=%0d want 0 0", ifu_stall_cycles, lsu_stall_cycles);
    end
`endif
  endtask

  task automatic test_ebreak();
    int reqs;
    reqs = 0;
    do_reset();
    tick();  // FETCH
    inst_type = INST_EBREAK;
    ifu_respValid = 1'b1;
    #1;
    checks++;
    if ({pc_wen, reg_wen} !== 2'b11) begin
      errors++;
      $display("FAIL ebreak_resp: got %b want 11", {pc_wen, reg_wen});
    end
    tick();  // EXEC
    ifu_respValid = 1'b0;
    #1;
    checks++;
    if ({ebreak, ifu_reqValid, halted} !== 3'b100) begin
      errors++;
      $display("FAIL ebreak_exec: got %b want 100", {ebreak, ifu_reqValid, halted});
    end
    tick();  // HALT
    checks++;
    if ({halted, finished, retire_count} !== {2'b11, 32'd1}) begin
      errors++;
      $display("FAIL ebreak_halt: got halted=%b fin=%b cnt=%0d want 1 1 1",
               halted, finished, retire_count);
    end
    for (int i = 0; i < 100; i++) begin
      reqs += int'(ifu_reqValid | lsu_reqValid);
      tick();
    end
    checks++;
    if (reqs != 0 || {halted, ebreak} !== 2'b11) begin
      errors++;
      $display("FAIL ebreak_hold: got reqs=%0d halted=%b ebreak=%b want 0 1 1",
               reqs, halted, ebreak);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    tick();  // FETCH wait 1
    tick();  // FETCH wait 2
    reset = 1'b1;
    #1;
    checks++;
    if ({ifu_reqValid, trap} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_idle: got %b want 00", {ifu_reqValid, trap});
    end
    tick();
    reset = 1'b0;  // START, stale response arrives now
    ifu_respValid = 1'b1;
    inst_type = INST_ALU;
    #1;
    checks++;
    if ({pc_wen, ifu_reqValid} !== 2'b01) begin
      errors++;
      $display("FAIL midreset_stale: got %b want 01", {pc_wen, ifu_reqValid});
    end
    tick();  // FETCH wait 1
    ifu_respValid = 1'b0;
    #1;
    checks++;
    if ({pc_wen, ifu_reqValid} !== 2'b01) begin
      errors++;
      $display("FAIL midreset_wait: got %b want 01", {pc_wen, ifu_reqValid});
    end
    tick();  // FETCH, genuine response
    ifu_respValid = 1'b1;
    #1;
    checks++;
    if ({pc_wen, reg_wen} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_resp: got %b want 11", {pc_wen, reg_wen});
    end
    tick();  // EXEC
    ifu_respValid = 1'b0;
    tick();
    checks++;
    if ({finished, trap, retire_count} !== {2'b10, 32'd1}) begin
      errors++;
      $display("FAIL midreset_retire: got fin=%b trap=%b cnt=%0d want 1 0 1",
               finished, trap, retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store_err();
    test_timeout();
    test_ebreak();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000ns want completion");
    $fatal(1, "bench timeout");
  end

endmodule
